// File: rtl/adaptive_thresh7x7.sv
// Adaptive threshold stage behind the 7x7 mean filter. It pairs each windowed mean with its
// buffered centre pixel and emits a 0/255 decision tagged with the centre coordinates.
module adaptive_thresh7x7 #(
    parameter int unsigned IMAGE_WIDTH = 320,
    parameter int unsigned BUF_ROWS    = 8,
    parameter int unsigned OFFSET      = 8,
    parameter int unsigned ROW_W       = 16,
    parameter int unsigned COL_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             gray_valid,
    input  logic [7:0]       gray,
    input  logic             mean_valid,
    input  logic [7:0]       mean_in,
    input  logic [ROW_W-1:0] center_row,
    input  logic [COL_W-1:0] center_col,
    output logic             bin_valid,
    output logic [7:0]       bin_out,
    output logic [ROW_W-1:0] bin_row,
    output logic [COL_W-1:0] bin_col,
    output logic             err
);
    localparam int unsigned Depth = BUF_ROWS * IMAGE_WIDTH;
    localparam int unsigned AddrW = $clog2(Depth);
    localparam int unsigned SlotW = $clog2(BUF_ROWS);
    localparam logic [ROW_W-1:0] RowMax  = '1;
    localparam logic [ROW_W-1:0] RowSpan = ROW_W'(BUF_ROWS);
    localparam logic [COL_W-1:0] ColLast = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [COL_W-1:0] ColLim  = COL_W'(IMAGE_WIDTH);
    localparam logic [9:0]       Bias    = 10'(OFFSET);

    logic [7:0] mem [Depth];

    logic [ROW_W-1:0] wr_row_q, wr_row_d, cur_row;
    logic [COL_W-1:0] wr_col_q, wr_col_d, cur_col;
    logic [AddrW-1:0] wr_addr, rd_addr;
    logic [ROW_W-1:0] row_dist;
    logic             behind, in_window, accept, reject;

    logic             s1_valid;
    logic [7:0]       s1_pix, s1_mean;
    logic [ROW_W-1:0] s1_row;
    logic [COL_W-1:0] s1_col;
    logic             s1_fire;

    function automatic logic [AddrW-1:0] buf_addr(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
        return AddrW'(row[SlotW-1:0]) * AddrW'(IMAGE_WIDTH) + AddrW'(col);
    endfunction

    // A frame_start pixel lands at (0,0) of the new frame.
    always_comb begin
        cur_row  = frame_start ? '0 : wr_row_q;
        cur_col  = frame_start ? '0 : wr_col_q;
        wr_row_d = cur_row;
        wr_col_d = cur_col;
        if (gray_valid) begin
            if (cur_col == ColLast) begin
                wr_col_d = '0;
                if (cur_row != RowMax) wr_row_d = cur_row + ROW_W'(1);
            end else begin
                wr_col_d = cur_col + COL_W'(1);
            end
        end
    end

    // Window is judged against the counters before this cycle's write.
    assign behind    = (center_row < wr_row_q) ||
                       ((center_row == wr_row_q) && (center_col < wr_col_q));
    assign row_dist  = wr_row_q - center_row;
    assign in_window = behind && (row_dist < RowSpan) && (center_col < ColLim);
    assign accept    = mean_valid && !frame_start && in_window;
    assign reject    = mean_valid && !frame_start && !in_window;

    assign wr_addr = buf_addr(cur_row, cur_col);
    assign rd_addr = buf_addr(center_row, center_col);
    assign s1_fire = s1_valid && !frame_start;

    always_ff @(posedge clk) begin
        if (gray_valid) mem[wr_addr] <= gray;
        if (accept) s1_pix <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_row_q  <= '0;
            wr_col_q  <= '0;
            err       <= 1'b0;
            s1_valid  <= 1'b0;
            s1_mean   <= '0;
            s1_row    <= '0;
            s1_col    <= '0;
            bin_valid <= 1'b0;
            bin_out   <= '0;
            bin_row   <= '0;
            bin_col   <= '0;
        end else begin
            wr_row_q <= wr_row_d;
            wr_col_q <= wr_col_d;
            if (frame_start) begin
                err <= 1'b0;
            end else if (reject) begin
                err <= 1'b1;
            end
            s1_valid <= accept;
            if (accept) begin
                s1_mean <= mean_in;
                s1_row  <= center_row;
                s1_col  <= center_col;
            end
            bin_valid <= s1_fire;
            if (s1_fire) begin
                bin_out <= (({2'b00, s1_pix} + Bias) > {2'b00, s1_mean}) ? 8'hFF : 8'h00;
                bin_row <= s1_row;
                bin_col <= s1_col;
            end
        end
    end
endmodule

// File: tb/tb_adaptive_thresh7x7.sv
// Bench for adaptive_thresh7x7: a table of compare vectors, hand sequences for window and
// reset corners, and randomized traffic checked against an image-array reference model.
module tb_adaptive_thresh7x7;
    localparam int W    = 320;
    localparam int NB   = 8;
    localparam int OFS  = 8;
    localparam int MAXR = 64;
    localparam int NV   = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_start = 1'b0;
    logic        gray_valid = 1'b0;
    logic [7:0]  gray = '0;
    logic        mean_valid = 1'b0;
    logic [7:0]  mean_in = '0;
    logic [15:0] center_row = '0;
    logic [15:0] center_col = '0;
    logic        bin_valid;
    logic [7:0]  bin_out;
    logic [15:0] bin_row;
    logic [15:0] bin_col;
    logic        err;

    adaptive_thresh7x7 #(
        .IMAGE_WIDTH(W),
        .BUF_ROWS   (NB),
        .OFFSET     (OFS),
        .ROW_W      (16),
        .COL_W      (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .gray_valid (gray_valid),
        .gray       (gray),
        .mean_valid (mean_valid),
        .mean_in    (mean_in),
        .center_row (center_row),
        .center_col (center_col),
        .bin_valid  (bin_valid),
        .bin_out    (bin_out),
        .bin_row    (bin_row),
        .bin_col    (bin_col),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct { bit v; int val; int row; int col; } res_t;
    typedef struct { int pix; int mean; int exp_out; } vec_t;

    logic [7:0] img [MAXR][W];
    int   m_row, m_col;
    bit   m_err;
    res_t m_s1, m_out;
    int   checks = 0;
    int   failures = 0;
    int   seen_valid = 0;
    vec_t tbl [NV];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_row = 0; m_col = 0; m_err = 1'b0;
        m_s1.v = 1'b0; m_out.v = 1'b0;
    endtask

    // One clock: drive inputs, predict from the image model, then check outputs #1 after the edge.
    task automatic cycle(input bit fs, input bit gv, input int g, input bit mv, input int m,
                         input int r, input int c);
        res_t p;
        bit   inwin;
        frame_start = fs; gray_valid = gv; gray = 8'(g);
        mean_valid = mv; mean_in = 8'(m); center_row = 16'(r); center_col = 16'(c);
        p.v = 1'b0; p.val = 0; p.row = 0; p.col = 0; inwin = 1'b0;
        if (mv && !fs) begin
            inwin = ((r < m_row) || (r == m_row && c < m_col)) && (m_row - r < NB) && (c < W);
            if (inwin) begin
                p.v = 1'b1;
                p.val = (int'(img[r][c]) + OFS > m) ? 255 : 0;
                p.row = r; p.col = c;
            end
        end
        @(posedge clk); #1;
        if (fs) begin
            model_reset();
        end else begin
            m_out = m_s1;
            m_s1 = p;
            if (mv && !inwin) m_err = 1'b1;
        end
        if (gv) begin
            img[m_row][m_col] = 8'(g);
            if (m_col == W - 1) begin
                m_col = 0; m_row++;
            end else begin
                m_col++;
            end
        end
        if (bin_valid) seen_valid++;
        chk("valid", int'(bin_valid), int'(m_out.v));
        if (m_out.v) begin
            chk("bin_out", int'(bin_out), m_out.val);
            chk("bin_row", int'(bin_row), m_out.row);
            chk("bin_col", int'(bin_col), m_out.col);
        end
        chk("err", int'(err), int'(m_err));
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 0, 1'b0, 0, 0, 0);
    endtask

    task automatic write_px(input int n);
        for (int i = 0; i < n; i++)
            cycle(1'b0, 1'b1, (m_row == 3 && m_col == 3) ? 100 : int'($urandom_range(0, 255)),
                  1'b0, 0, 0, 0);
    endtask

    initial begin
        int r, c, s0;
        bit fs;
        tbl[0] = '{100, 105, 255}; tbl[1] = '{100, 108, 0};   tbl[2] = '{100, 107, 255};
        tbl[3] = '{255, 255, 255}; tbl[4] = '{255, 0, 255};   tbl[5] = '{0, 8, 0};
        tbl[6] = '{0, 7, 255};     tbl[7] = '{0, 0, 255};     tbl[8] = '{247, 255, 0};
        tbl[9] = '{248, 255, 255};

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", int'(bin_valid), 0);
        chk("rst_out", int'(bin_out), 0);
        chk("rst_row", int'(bin_row), 0);
        chk("rst_col", int'(bin_col), 0);
        chk("rst_err", int'(err), 0);
        #1 rst = 1'b1;

        // Compare boundaries from a fixed table, pixels on row 0.
        cycle(1'b1, 1'b0, 0, 1'b0, 0, 0, 0);
        for (int i = 0; i < NV; i++) cycle(1'b0, 1'b1, tbl[i].pix, 1'b0, 0, 0, 0);
        for (int i = 0; i < NV; i++) begin
            cycle(1'b0, 1'b0, 0, 1'b1, tbl[i].mean, 0, i);
            idle();
            chk("tbl_valid", int'(bin_valid), 1);
            chk("tbl_out", int'(bin_out), tbl[i].exp_out);
            idle();
        end

        // Single sample at (3,3) after row 4 is written.
        cycle(1'b1, 1'b0, 0, 1'b0, 0, 0, 0);
        write_px(5 * W);
        cycle(1'b0, 1'b0, 0, 1'b1, 105, 3, 3);
        idle();
        chk("t1_valid", int'(bin_valid), 1);
        chk("t1_out", int'(bin_out), 255);
        chk("t1_row", int'(bin_row), 3);
        chk("t1_col", int'(bin_col), 3);
        idle();
        cycle(1'b0, 1'b0, 0, 1'b1, 108, 3, 3);
        idle();
        chk("t1b_out", int'(bin_out), 0);
        idle();

        // Lookahead: centre equals the write position.
        s0 = seen_valid;
        cycle(1'b0, 1'b0, 0, 1'b1, 50, 5, 0);
        idle(); idle();
        chk("look_drop", seen_valid - s0, 0);
        chk("look_err", int'(err), 1);
        cycle(1'b1, 1'b0, 0, 1'b0, 0, 0, 0);
        chk("look_clr", int'(err), 0);

        // Overrun: row 1 fell out of the buffer, row 3 did not.
        write_px(10 * W);
        s0 = seen_valid;
        cycle(1'b0, 1'b0, 0, 1'b1, 20, 1, 0);
        idle(); idle();
        chk("over_drop", seen_valid - s0, 0);
        chk("over_err", int'(err), 1);
        cycle(1'b0, 1'b0, 0, 1'b1, 20, 3, 5);
        idle();
        chk("over_ok", int'(bin_valid), 1);
        idle();

        // Burst: both strobes every cycle.
        s0 = seen_valid;
        for (int i = 0; i < 64; i++)
            cycle(1'b0, 1'b1, int'($urandom_range(0, 255)), 1'b1, int'($urandom_range(0, 255)),
                  m_row - 3, m_col);
        idle(); idle();
        chk("burst_count", seen_valid - s0, 64);

        // Randomized traffic.
        cycle(1'b1, 1'b0, 0, 1'b0, 0, 0, 0);
        for (int i = 0; i < 6000; i++) begin
            fs = (m_row >= 20) || ($urandom_range(0, 999) == 0);
            r = m_row - int'($urandom_range(0, 9));
            if (r < 0) r = 0;
            c = ($urandom_range(0, 15) == 0) ? int'($urandom_range(W, W + 20))
                                             : int'($urandom_range(0, W - 1));
            cycle(fs, $urandom_range(0, 9) < 8, int'($urandom_range(0, 255)),
                  $urandom_range(0, 1) == 1, int'($urandom_range(0, 255)), r, c);
        end

        // Reset with a result in flight.
        cycle(1'b1, 1'b0, 0, 1'b0, 0, 0, 0);
        write_px(2 * W);
        cycle(1'b0, 1'b0, 0, 1'b1, 50, 0, 5);
        rst = 1'b0;
        frame_start = 1'b0; gray_valid = 1'b0; mean_valid = 1'b0;
        #1;
        chk("rst_mid_valid", int'(bin_valid), 0);
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_hold_valid", int'(bin_valid), 0);
            chk("rst_hold_err", int'(err), 0);
        end
        rst = 1'b1;
        cycle(1'b0, 1'b1, 50, 1'b0, 0, 0, 0);
        cycle(1'b0, 1'b0, 0, 1'b1, 40, 0, 1);
        cycle(1'b0, 1'b0, 0, 1'b1, 40, 0, 0);
        idle();
        chk("rst_new_valid", int'(bin_valid), 1);
        chk("rst_new_out", int'(bin_out), 255);
        chk("rst_new_row", int'(bin_row), 0);
        chk("rst_new_col", int'(bin_col), 0);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
